// File: rtl/ysyx_22041405_lsu.sv
// ysyx_22041405_lsu -- load/store unit between the EXU and write-back.
//
// Takes one executed instruction at a time. Loads and stores do a single
// data-RAM access. Stores get byte-lane replication and a write mask. Loads get
// lane selection and sign/zero extension. Non-memory instructions are buffered
// for one cycle and handed to WB. Illegal or misaligned accesses never touch
// the RAM. They come out on wb_except, with the faulting address in wb_data.
//
// Ports
//   clk, rst             clock; asynchronous active-low reset
//   ex_valid/ex_ready    EXU handshake (ready only while idle)
//   ex_is_load/store     memory-op flags
//   ex_funct3            RV32I access size/sign code
//   ex_result            ALU result / effective address
//   ex_wdata, ex_rd      store data (rs2), destination register
//   dram_re/we           read/write request, held until dram_ack
//   dram_addr            word-aligned address
//   dram_wdata/wmask     lane-replicated store data, byte enables
//   dram_rdata/ack       read data and one-cycle completion pulse
//   wb_valid/wb_ready    WB handshake
//   wb_rd/we/data        register write-back
//   wb_except            misaligned or illegal access
module ysyx_22041405_lsu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic             ex_is_load,
  input  logic             ex_is_store,
  input  logic [2:0]       ex_funct3,
  input  logic [WIDTH-1:0] ex_result,
  input  logic [WIDTH-1:0] ex_wdata,
  input  logic [4:0]       ex_rd,
  output logic             dram_re,
  output logic             dram_we,
  output logic [WIDTH-1:0] dram_addr,
  output logic [WIDTH-1:0] dram_wdata,
  output logic [3:0]       dram_wmask,
  input  logic [WIDTH-1:0] dram_rdata,
  input  logic             dram_ack,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [4:0]       wb_rd,
  output logic             wb_we,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_except
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] storeData_q, storeData_d;
  logic [4:0]       rd_q, rd_d;
  logic             isLoad_q, isLoad_d;
  logic             isStore_q, isStore_d;
  logic [WIDTH-1:0] wbData_q, wbData_d;
  logic             wbWe_q, wbWe_d;
  logic             wbExcept_q, wbExcept_d;

  logic             exLoad, exStore, exLegal, exAligned;
  logic [WIDTH-1:0] laneShift, loadData, storeLanes;
  logic [3:0]       storeMask;

  // Decode the incoming instruction. A load takes priority if both flags are
  // set. Alignment only matters for legal codes, so illegal ones fall through.
  always_comb begin
    exLoad    = ex_is_load;
    exStore   = ex_is_store & ~ex_is_load;
    exLegal   = 1'b0;
    exAligned = 1'b1;
    if (exLoad) begin
      exLegal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010) ||
                (ex_funct3 == 3'b100) || (ex_funct3 == 3'b101);
    end else if (exStore) begin
      exLegal = (ex_funct3 == 3'b000) || (ex_funct3 == 3'b001) || (ex_funct3 == 3'b010);
    end
    case (ex_funct3[1:0])
      2'b01:   exAligned = ~ex_result[0];
      2'b10:   exAligned = (ex_result[1:0] == 2'b00);
      default: exAligned = 1'b1;
    endcase
  end

  // Shift the addressed byte/half down to bit 0, then extend it per funct3.
  // A word access is always aligned, so its shift is zero.
  always_comb begin
    laneShift = dram_rdata >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  loadData = {{(WIDTH-8){laneShift[7]}}, laneShift[7:0]};
      3'b001:  loadData = {{(WIDTH-16){laneShift[15]}}, laneShift[15:0]};
      3'b100:  loadData = {{(WIDTH-8){1'b0}}, laneShift[7:0]};
      3'b101:  loadData = {{(WIDTH-16){1'b0}}, laneShift[15:0]};
      default: loadData = laneShift;
    endcase
  end

  // Stores replicate the datum across every lane it could land in and let the
  // mask pick the real byte enables.
  always_comb begin
    case (funct3_q[1:0])
      2'b00: begin
        storeLanes = {4{storeData_q[7:0]}};
        storeMask  = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        storeLanes = {2{storeData_q[15:0]}};
        storeMask  = 4'b0011 << addr_q[1:0];
      end
      default: begin
        storeLanes = storeData_q;
        storeMask  = 4'b1111;
      end
    endcase
  end

  // Next-state logic. The instruction and the WB result are latched on
  // accept. A load's result is overwritten when its data arrives with dram_ack.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    storeData_d = storeData_q;
    rd_d        = rd_q;
    isLoad_d    = isLoad_q;
    isStore_d   = isStore_q;
    wbData_d    = wbData_q;
    wbWe_d      = wbWe_q;
    wbExcept_d  = wbExcept_q;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          funct3_d    = ex_funct3;
          addr_d      = ex_result;
          storeData_d = ex_wdata;
          rd_d        = ex_rd;
          isLoad_d    = exLoad;
          isStore_d   = exStore;
          if (exLoad || exStore) begin
            if (exLegal && exAligned) begin
              state_d    = REQ;
              wbData_d   = '0;
              wbWe_d     = 1'b0;
              wbExcept_d = 1'b0;
            end else begin
              state_d    = RESP;
              wbData_d   = ex_result;
              wbWe_d     = 1'b0;
              wbExcept_d = 1'b1;
            end
          end else begin
            state_d    = RESP;
            wbData_d   = ex_result;
            wbWe_d     = (ex_rd != 5'd0);
            wbExcept_d = 1'b0;
          end
        end
      end
      REQ: begin
        if (dram_ack) begin
          state_d    = RESP;
          wbExcept_d = 1'b0;
          if (isLoad_q) begin
            wbData_d = loadData;
            wbWe_d   = (rd_q != 5'd0);
          end else begin
            wbData_d = '0;
            wbWe_d   = 1'b0;
          end
        end
      end
      RESP: begin
        if (wb_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers. Reset abandons any request in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      funct3_q    <= '0;
      addr_q      <= '0;
      storeData_q <= '0;
      rd_q        <= '0;
      isLoad_q    <= 1'b0;
      isStore_q   <= 1'b0;
      wbData_q    <= '0;
      wbWe_q      <= 1'b0;
      wbExcept_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      storeData_q <= storeData_d;
      rd_q        <= rd_d;
      isLoad_q    <= isLoad_d;
      isStore_q   <= isStore_d;
      wbData_q    <= wbData_d;
      wbWe_q      <= wbWe_d;
      wbExcept_q  <= wbExcept_d;
    end
  end

  // Outputs are decoded from the state, so reset clears them immediately.
  // All dram_* and wb_* outputs are zero outside REQ and RESP respectively.
  always_comb begin
    ex_ready   = (state_q == IDLE);
    dram_re    = (state_q == REQ) && isLoad_q;
    dram_we    = (state_q == REQ) && isStore_q;
    dram_addr  = (state_q == REQ) ? {addr_q[WIDTH-1:2], 2'b00} : '0;
    dram_wdata = dram_we ? storeLanes : '0;
    dram_wmask = dram_we ? storeMask : 4'b0000;
    wb_valid   = (state_q == RESP);
    wb_rd      = wb_valid ? rd_q : 5'd0;
    wb_we      = wb_valid & wbWe_q;
    wb_data    = wb_valid ? wbData_q : '0;
    wb_except  = wb_valid & wbExcept_q;
  end

endmodule

// File: doc/ysyx_22041405_lsu.md
Name: ysyx_22041405_lsu

Overview:
- Load/store unit sitting directly downstream of the EXU and upstream of write-back.
- Accepts one executed instruction at a time, performs the data-RAM access for loads and stores, and hands the result to WB:
  - byte-lane alignment
  - write masks
  - sign/zero extension
- Non-memory instructions pass through with one cycle of buffering. Misaligned or illegal accesses are flagged and never reach memory.

Parameters:
- WIDTH, 32, data/address width (only 32 supported)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- ex_valid  in  1  EXU has an instruction
- ex_ready  out  1  LSU accepts this cycle
- ex_is_load  in  1  instruction is a load
- ex_is_store  in  1  instruction is a store
- ex_funct3  in  3  access size/sign (RV32I encoding)
- ex_result  in  WIDTH  ALU result; effective address for load/store
- ex_wdata  in  WIDTH  store data (rs2)
- ex_rd  in  5  destination register
- dram_re  out  1  read request
- dram_we  out  1  write request
- dram_addr  out  WIDTH  word-aligned address
- dram_wdata  out  WIDTH  lane-replicated store data
- dram_wmask  out  4  byte write enables
- dram_rdata  in  WIDTH  read data, valid with dram_ack
- dram_ack  in  1  one-cycle pulse: read data valid / write done
- wb_valid  out  1  result available
- wb_ready  in  1  WB consumes
- wb_rd  out  5  destination register
- wb_we  out  1  register write enable
- wb_data  out  WIDTH  write-back data
- wb_except  out  1  misaligned or illegal access

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0 except ex_ready=1. A request in flight is abandoned and dram_re/dram_we drop immediately.
- FSM states IDLE, REQ, RESP.
  - ex_ready = (state==IDLE).
  - Accept = ex_valid & ex_ready. On accept, latch funct3, result, wdata, rd, and load/store flags.
- IDLE, on accept:
  - Load/store, legal and aligned -> REQ.
  - Anything else -> RESP.
- Legality:
  - Load funct3 ∈ {000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU}.
  - Store funct3 ∈ {000 SB, 001 SH, 010 SW}.
  - Other codes are illegal.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=00.
- Illegal or misaligned: RESP with wb_except=1, wb_we=0, wb_data=address; no dram access.
- Non-memory: RESP with wb_data=ex_result, wb_we=(rd!=0), wb_except=0.
- REQ:
  - dram_re (load) or dram_we (store) held high, dram_addr={addr[31:2],2'b00}, all dram outputs stable until dram_ack.
  - dram_ack may arrive in the first REQ cycle or later; no timeout.
  - On dram_ack: -> RESP; dram_re/dram_we deassert the next cycle.
- Stores:
  - SB: wdata={4{b}}, wmask=0001<<addr[1:0].
  - SH: wdata={2{h}}, wmask=0011<<addr[1:0].
  - SW: wmask=1111.
  - Store result: wb_we=0, wb_data=0.
- Loads:
  - Lane select by addr[1:0] from dram_rdata captured on dram_ack.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - wb_we=(rd!=0).
  - Dram outputs are 0 outside REQ.
- RESP:
  - wb_valid=1 and wb_* stable until wb_ready; then -> IDLE.
  - wb_ready high in the same cycle as RESP entry: the transfer completes that cycle.
  - Minimum throughput: non-memory 1 instruction / 2 cycles; memory op = 2 + ack latency.
- wb_ready is ignored outside RESP. dram_ack outside REQ is ignored.
- ex_* is only sampled on accept, so changes while busy have no effect.

Test Plan:
- Pass-through: ex_result=0x12345678, rd=5, not load/store, wb_ready=1 -> wb_valid next cycle, wb_data=0x12345678, wb_we=1; with rd=0, wb_we=0.
- SB: addr=0x80000003, wdata=0x000000AB, ack after 3 cycles -> dram_addr=0x80000000, wmask=1000, wdata=0xABABABAB held 3 cycles; wb_we=0.
- Loads: dram_rdata=0x80FF7F01.
  - LB @+2 -> 0xFFFFFFFF.
  - LBU @+3 -> 0x00000080.
  - LH @+0 -> 0x00007F01.
  - LHU @+2 -> 0x000080FF.
  - LW -> 0x80FF7F01.
- Misaligned/illegal:
  - LW @0x80000002 -> no dram_re, wb_except=1, wb_data=0x80000002, wb_we=0.
  - funct3=011 load -> same exception.
- Backpressure: wb_ready=0 for 4 cycles after load completes -> wb_* stable and ex_ready=0 throughout; accepts the next instruction the cycle after wb_ready.
- Reset mid-op: rst low during REQ with dram_re=1 -> dram_re=0 immediately, wb_valid=0, ex_ready=1; a late dram_ack after reset is ignored.
